// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Oversampling UART receiver (16 sample ticks per bit). The line is
//   resynchronised into the clk_100MHz domain. Each bit is sampled near its
//   middle: the start bit is confirmed 8 ticks after the falling edge, and
//   each data bit and the stop bit are sampled 16 ticks after the previous
//   sample. Data bits arrive LSB first.
//
// Parameters
//   DBITS        data bits per frame (at least 2)
//   SB_TICK      sample ticks spent in the stop bit
//
// Ports
//   clk_100MHz     in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   rx             in   serial line, idle high, asynchronous to clk_100MHz
//   sample_tick    in   one-clock pulse at 16x the baud rate
//   data_ready     out  one-clock pulse when a frame completes
//   data_out       out  last received word, held until the next frame completes
//   framing_error  out  stop bit of the last frame was sampled low (held)
//   state_dbg      out  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Output protocol: data_ready is a strobe with no back-pressure. data_out and
// framing_error are valid in the same cycle as data_ready and stay stable
// until the next strobe.
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic             data_ready,
    output logic [DBITS-1:0] data_out,
    output logic             framing_error,
    output logic [1:0]       state_dbg
);

    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [3:0]    S_MID   = 4'd7;
    localparam logic [3:0]    S_BIT   = 4'd15;
    localparam logic [3:0]    S_STOP  = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);

    logic             rx_meta;
    logic             rx_s;
    logic [1:0]       state;
    logic [3:0]       s;
    logic [NW-1:0]    n;
    logic [DBITS-1:0] b;

    assign state_dbg = state;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            s             <= '0;
            n             <= '0;
            b             <= '0;
            data_out      <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // Falling edge detection does not wait for a tick.
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                n     <= '0;
                            end else begin
                                // Line went back high before mid start bit: glitch.
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        if (s == S_BIT) begin
                            s <= '0;
                            b <= {rx_s, b[DBITS-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (s == S_STOP) begin
                            s             <= '0;
                            state         <= IDLE;
                            data_out      <= b;
                            data_ready    <= 1'b1;
                            framing_error <= ~rx_s;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver (DBITS=8, SB_TICK=16). sample_tick
//   pulses every 4 clocks; one bit lasts 16 ticks. Completed frames are
//   captured by a monitor and compared against an expected queue.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic       clk_100MHz;
    logic       reset;
    logic       rx;
    logic       sample_tick;
    logic       data_ready;
    logic [7:0] data_out;
    logic       framing_error;
    logic [1:0] state_dbg;

    logic       tick_en;
    int         tick_cnt;
    int         checks;
    int         errors;
    logic       prev_dr;

    // {framing_error, data}
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[5];

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .rx            (rx),
        .sample_tick   (sample_tick),
        .data_ready    (data_ready),
        .data_out      (data_out),
        .framing_error (framing_error),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset / tick generation ----------------
    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        tick_cnt    = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            tick_cnt    = tick_cnt + 1;
            sample_tick = ((tick_cnt % 4) == 0) && tick_en;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        prev_dr = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            if (data_ready === 1'b1) begin
                check("data_ready_single_cycle", {31'd0, prev_dr}, 32'd0);
                got_q.push_back({framing_error, data_out});
            end
            prev_dr = data_ready;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge after the k-th observed tick, so rx changes
    // away from the active edge.
    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge clk_100MHz);
            while (sample_tick !== 1'b1) @(posedge clk_100MHz);
        end
        @(negedge clk_100MHz);
    endtask

    // Sends one frame. stall_bit >= 0 freezes sample_tick for 1000 clocks
    // in the middle of that data bit and checks that nothing advances.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stall_bit);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == stall_bit) begin
                wait_ticks(5);
                check("stall_state_before", {30'd0, state_dbg}, {30'd0, ST_DATA});
                tick_en = 1'b0;
                repeat (1000) @(posedge clk_100MHz);
                @(negedge clk_100MHz);
                check("stall_state_after", {30'd0, state_dbg}, {30'd0, ST_DATA});
                check("stall_no_ready", got_q.size(), 32'd0);
                tick_en = 1'b1;
                wait_ticks(11);
            end else begin
                wait_ticks(16);
            end
        end
        rx = stop_v;
        if (stop_v) begin
            wait_ticks(16);
        end else begin
            // Low long enough to be sampled mid-bit, then back to idle.
            wait_ticks(12);
            rx = 1'b1;
            wait_ticks(4);
        end
    endtask

    task automatic idle_ticks(input int k);
        rx = 1'b1;
        wait_ticks(k);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_frames(input string name);
        logic [8:0] g;
        logic [8:0] e;
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_data"}, {24'd0, g[7:0]}, {24'd0, e[7:0]});
            check({name, "_ferr"}, {31'd0, g[8]}, {31'd0, e[8]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        rx      = 1'b1;
        tick_en = 1'b1;

        vecs[0] = '{name: "frame_a5",      data: 8'hA5, stop_bit: 1'b1, exp_data: 8'hA5, exp_fe: 1'b0};
        vecs[1] = '{name: "frame_3c_ferr", data: 8'h3C, stop_bit: 1'b0, exp_data: 8'h3C, exp_fe: 1'b1};
        vecs[2] = '{name: "frame_00",      data: 8'h00, stop_bit: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
        vecs[3] = '{name: "frame_7e",      data: 8'h7E, stop_bit: 1'b1, exp_data: 8'h7E, exp_fe: 1'b0};
        vecs[4] = '{name: "frame_01_ferr", data: 8'h01, stop_bit: 1'b0, exp_data: 8'h01, exp_fe: 1'b1};

        repeat (5) @(negedge clk_100MHz);
        check("reset_data_out",  {24'd0, data_out},      32'd0);
        check("reset_ready",     {31'd0, data_ready},    32'd0);
        check("reset_ferr",      {31'd0, framing_error}, 32'd0);
        check("reset_state",     {30'd0, state_dbg},     {30'd0, ST_IDLE});
        reset = 1'b0;
        idle_ticks(8);
        got_q.delete();

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, -1);
            exp_q.push_back({vecs[i].exp_fe, vecs[i].exp_data});
            idle_ticks(32);
            check_frames(vecs[i].name);
            check({vecs[i].name, "_held_data"}, {24'd0, data_out},      {24'd0, vecs[i].exp_data});
            check({vecs[i].name, "_held_ferr"}, {31'd0, framing_error}, {31'd0, vecs[i].exp_fe});
        end

        // Framing error cleared by a valid 0x00 frame.
        send_frame(8'h3C, 1'b0, -1);
        idle_ticks(32);
        check("ferr_set", {31'd0, framing_error}, 32'd1);
        got_q.delete();
        send_frame(8'h00, 1'b1, -1);
        exp_q.push_back({1'b0, 8'h00});
        idle_ticks(32);
        check_frames("ferr_clear");
        check("ferr_clear_level", {31'd0, framing_error}, 32'd0);

        // Set a known nonzero data_out, then a 3-tick glitch.
        send_frame(8'hC3, 1'b1, -1);
        exp_q.push_back({1'b0, 8'hC3});
        idle_ticks(32);
        check_frames("pre_glitch");
        rx = 1'b0;
        wait_ticks(3);
        idle_ticks(20);
        check("glitch_no_ready", got_q.size(), 32'd0);
        check("glitch_state",    {30'd0, state_dbg}, {30'd0, ST_IDLE});
        check("glitch_data_out", {24'd0, data_out},  32'h0000_00C3);

        // Back-to-back frames, no idle gap.
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hFF});
        idle_ticks(32);
        check_frames("back_to_back");

        // Reset in the middle of data bit 4 of 0x81.
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            wait_ticks(16);
        end
        rx = 1'b0;
        wait_ticks(8);
        reset = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        check("midreset_data_out", {24'd0, data_out},      32'd0);
        check("midreset_ready",    {31'd0, data_ready},    32'd0);
        check("midreset_ferr",     {31'd0, framing_error}, 32'd0);
        check("midreset_state",    {30'd0, state_dbg},     {30'd0, ST_IDLE});
        reset = 1'b0;
        idle_ticks(16);
        check("midreset_no_ready", got_q.size(), 32'd0);
        send_frame(8'h81, 1'b1, -1);
        exp_q.push_back({1'b0, 8'h81});
        idle_ticks(32);
        check_frames("after_reset");

        // Tick stall in the middle of data bit 3.
        send_frame(8'h5A, 1'b1, 3);
        exp_q.push_back({1'b0, 8'h5A});
        idle_ticks(32);
        check_frames("tick_stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DBITS, default 8, meaning the number of data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning the number of sample ticks in the stop bit.
REQ-003 The block SHALL have port clk_100MHz  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 The block SHALL have port sample_tick  input  1  one-clock pulse at 16x baud, from the baud rate generator.
REQ-007 The block SHALL have port data_ready  output  1  one-clock pulse when a frame completes.
REQ-008 The block SHALL have port data_out  output  DBITS  last received byte; held until the next frame completes.
REQ-009 The block SHALL have port framing_error  output  1  stop bit of the last completed frame sampled low; held until the next frame completes.

Function
REQ-010 The block SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle input latency).
REQ-011 The block SHALL implement the FSM states IDLE, START, DATA and STOP, with a 4-bit tick counter s, a bit counter n of width clog2(DBITS), and a DBITS-wide shift register b.
REQ-012 IDLE: when rx_s==0, the block SHALL go to START with s=0; otherwise it SHALL stay in IDLE, ignoring sample_tick.
REQ-013 START: on each sample_tick with s<7, the block SHALL increment s.
REQ-014 START: on a sample_tick with s==7 (mid start bit), if rx_s==0 the block SHALL go to DATA with s=0 and n=0.
REQ-015 START: on a sample_tick with s==7 and rx_s==1, the block SHALL treat the event as a glitch and return to IDLE with no output change.
REQ-016 DATA: on each sample_tick with s<15, the block SHALL increment s.
REQ-017 DATA: on a sample_tick with s==15, the block SHALL set s=0 and shift b <= {rx_s, b[DBITS-1:1]} (LSB first).
REQ-018 DATA: on that same tick, if n==DBITS-1 the block SHALL go to STOP; otherwise it SHALL increment n.
REQ-019 STOP: on each sample_tick with s<SB_TICK-1, the block SHALL increment s.
REQ-020 STOP: on a sample_tick with s==SB_TICK-1, on the next clock edge the block SHALL set data_out<=b, data_ready<=1 and framing_error<=~rx_s, then return to IDLE.
REQ-021 data_ready SHALL be high for exactly one clock per completed frame, including frames with framing_error=1.
REQ-022 Outside a completion event, data_out and framing_error SHALL hold their values.
REQ-023 Cycles without sample_tick SHALL leave s, n, b and the state unchanged, except for the IDLE->START transition.
REQ-024 A low rx_s at the instant of return to IDLE SHALL start a new frame on the next cycle (back-to-back frames, no idle gap required).
REQ-025 Counters SHALL never wrap: s is cleared on every state transition and n on entry to DATA.
REQ-026 A continuously low line (break) SHALL produce frames of data 0x00 with framing_error=1 repeatedly.

Reset
REQ-027 While reset is high, the block SHALL hold the state at IDLE, s, n, b and data_out at 0, data_ready at 0, framing_error at 0, and both synchronizer flops at 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no data_ready; after reset is released, the block SHALL wait for a new falling edge.

Verification
REQ-029 The bench SHALL cover: sample_tick every 4 clocks, serial 0xA5 sent (start, 1,0,1,0,0,1,0,1, stop high) -> one data_ready pulse, data_out=0xA5, framing_error=0.
REQ-030 The bench SHALL cover: byte 0x3C sent with the stop bit held low -> data_ready pulse, data_out=0x3C, framing_error=1; a following valid 0x00 frame clears framing_error.
REQ-031 The bench SHALL cover: a low pulse of 3 ticks on an idle line -> no data_ready, FSM back in IDLE, data_out unchanged.
REQ-032 The bench SHALL cover: frames 0x55 then 0xFF sent back-to-back with no idle gap -> two data_ready pulses, in order, with correct data.
REQ-033 The bench SHALL cover: reset asserted during data bit 4 of 0x81, then a clean 0x81 sent -> data_out=0x00 during reset, then exactly one data_ready pulse with 0x81.
REQ-034 The bench SHALL cover: sample_tick held low for 1000 clocks mid-frame -> no state progress, and the frame completes correctly once ticks resume.
